// File: rtl/vqe_sweep_scheduler_if.sv
// Bundle between the VQE sweep scheduler and its surroundings.
// The master modport is the scheduler side and the slave modport is the consumer side.
// The argmin tracking signals exist only when VQE_ARGMIN_EN is defined.
interface vqe_sweep_scheduler_if #(
  parameter int N_ANG0   = 4,
  parameter int N_ANG1   = 4,
  parameter int ENERGY_W = 16
);
  localparam int ANG0_W = (N_ANG0 > 1) ? $clog2(N_ANG0) : 1;
  localparam int ANG1_W = (N_ANG1 > 1) ? $clog2(N_ANG1) : 1;
  localparam int SLOT_W = ((N_ANG0 * N_ANG1) > 1) ? $clog2(N_ANG0 * N_ANG1) : 1;

  logic              start;
  logic              listener_flag;
  logic [ANG0_W-1:0] ang0_idx;
  logic [ANG1_W-1:0] ang1_idx;
  logic              cap_we;
  logic [SLOT_W-1:0] cap_slot;
  logic              busy;
  logic              source_flag;

`ifdef VQE_ARGMIN_EN
  logic signed [ENERGY_W-1:0] energy;
  logic        [SLOT_W-1:0]   min_slot;
  logic signed [ENERGY_W-1:0] min_energy;

  modport master (
    input  start, listener_flag, energy,
    output ang0_idx, ang1_idx, cap_we, cap_slot, busy, source_flag,
    output min_slot, min_energy
  );

  modport slave (
    output start, listener_flag, energy,
    input  ang0_idx, ang1_idx, cap_we, cap_slot, busy, source_flag,
    input  min_slot, min_energy
  );
`else
  modport master (
    input  start, listener_flag,
    output ang0_idx, ang1_idx, cap_we, cap_slot, busy, source_flag
  );

  modport slave (
    output start, listener_flag,
    input  ang0_idx, ang1_idx, cap_we, cap_slot, busy, source_flag
  );
`endif

endinterface

// File: rtl/vqe_sweep_scheduler.sv
// VQE sweep scheduler: walks the (ang0, ang1) angle grid, with ang1 as the inner loop.
// Each grid point gets SETTLE_CYC settle cycles and then one capture cycle.
// The capture cycle strobes cap_we for the point's result slot.
// After the last capture it raises source_flag and holds it until listener_flag acknowledges.
// Optional macro VQE_ARGMIN_EN adds tracking of the minimum captured energy and its slot.
module vqe_sweep_scheduler #(
  parameter int N_ANG0     = 4,
  parameter int N_ANG1     = 4,
  parameter int SETTLE_CYC = 1,
  parameter int ENERGY_W   = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  vqe_sweep_scheduler_if.master bus
);

  localparam int ANG0_W = (N_ANG0 > 1) ? $clog2(N_ANG0) : 1;
  localparam int ANG1_W = (N_ANG1 > 1) ? $clog2(N_ANG1) : 1;
  localparam int SLOT_W = ((N_ANG0 * N_ANG1) > 1) ? $clog2(N_ANG0 * N_ANG1) : 1;
  localparam int CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [ANG0_W-1:0] LAST0  = ANG0_W'(N_ANG0 - 1);
  localparam logic [ANG1_W-1:0] LAST1  = ANG1_W'(N_ANG1 - 1);
  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [ANG0_W-1:0] ang0_q, ang0_next;
  logic [ANG1_W-1:0] ang1_q, ang1_next;
  logic [SLOT_W-1:0] slot_q, slot_next;
  logic [CNT_W-1:0]  cnt_q, cnt_next;
  logic              cap_we_q, cap_we_next;
  logic              busy_q, busy_next;
  logic              source_q, source_next;

  // Next-state logic: compute the next state and grid position.
  // The registered outputs are derived from the state being entered.
  always_comb begin
    state_next = state;
    ang0_next  = ang0_q;
    ang1_next  = ang1_q;
    slot_next  = slot_q;
    cnt_next   = cnt_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = SETTLE;
          ang0_next  = '0;
          ang1_next  = '0;
          slot_next  = '0;
          cnt_next   = RELOAD;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_next = CAPTURE;
        end else begin
          cnt_next = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        if ((ang0_q == LAST0) && (ang1_q == LAST1)) begin
          state_next = DONE;
        end else begin
          state_next = SETTLE;
          cnt_next   = RELOAD;
          slot_next  = slot_q + SLOT_W'(1);
          if (ang1_q == LAST1) begin
            ang1_next = '0;
            ang0_next = ang0_q + ANG0_W'(1);
          end else begin
            ang1_next = ang1_q + ANG1_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.listener_flag) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    cap_we_next = (state_next == CAPTURE);
    busy_next   = (state_next == SETTLE) || (state_next == CAPTURE);
    source_next = (state_next == DONE);
  end

  // State and output registers; reset overrides everything, including a sweep in progress.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= IDLE;
      ang0_q   <= '0;
      ang1_q   <= '0;
      slot_q   <= '0;
      cnt_q    <= '0;
      cap_we_q <= 1'b0;
      busy_q   <= 1'b0;
      source_q <= 1'b0;
    end else begin
      state    <= state_next;
      ang0_q   <= ang0_next;
      ang1_q   <= ang1_next;
      slot_q   <= slot_next;
      cnt_q    <= cnt_next;
      cap_we_q <= cap_we_next;
      busy_q   <= busy_next;
      source_q <= source_next;
    end
  end

  assign bus.ang0_idx    = ang0_q;
  assign bus.ang1_idx    = ang1_q;
  assign bus.cap_slot    = slot_q;
  assign bus.cap_we      = cap_we_q;
  assign bus.busy        = busy_q;
  assign bus.source_flag = source_q;

`ifdef VQE_ARGMIN_EN
  logic        [SLOT_W-1:0]   min_slot_q;
  logic signed [ENERGY_W-1:0] min_energy_q;

  // Argmin tracker: slot 0 is always the first capture of a sweep, so it seeds the minimum.
  // Later captures replace the minimum only on a strictly smaller energy, so ties keep the earlier slot.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      min_slot_q   <= '0;
      min_energy_q <= '0;
    end else if (state == CAPTURE) begin
      if ((slot_q == '0) || (bus.energy < min_energy_q)) begin
        min_slot_q   <= slot_q;
        min_energy_q <= bus.energy;
      end
    end
  end

  assign bus.min_slot   = min_slot_q;
  assign bus.min_energy = min_energy_q;
`endif

endmodule

// File: tb/tb_vqe_sweep_scheduler.sv
// Bench for vqe_sweep_scheduler.
// Two instances are driven: the default 4x4 grid with settle 1, and a 2x3 grid with settle 3.
// Expected behaviour comes from closed-form sweep timing: point p occupies cycles p*(S+1)+1 .. (p+1)*(S+1) after start.
// Define VQE_ARGMIN_EN to also check the minimum-energy tracker.
module tb_vqe_sweep_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n0_tab[2] = '{4, 2};
  int n1_tab[2] = '{4, 3};
  int s_tab[2]  = '{1, 3};

  int checks = 0;
  int errors = 0;

  logic                drv_start[2];
  logic                drv_listener[2];
  logic signed [15:0]  drv_energy[2];
  logic signed [15:0]  energy_tab[2][16];

  logic       o_cap[2];
  logic       o_busy[2];
  logic       o_src[2];
  logic [7:0] o_slot[2];
  logic [7:0] o_a0[2];
  logic [7:0] o_a1[2];
  logic [7:0]         o_min_slot[2];
  logic signed [15:0] o_min_e[2];

  vqe_sweep_scheduler_if #(.N_ANG0(4), .N_ANG1(4), .ENERGY_W(16)) if_a ();
  vqe_sweep_scheduler_if #(.N_ANG0(2), .N_ANG1(3), .ENERGY_W(16)) if_b ();

  vqe_sweep_scheduler #(.N_ANG0(4), .N_ANG1(4), .SETTLE_CYC(1), .ENERGY_W(16)) dut_a (
    .i_clock(clk), .i_reset(rst), .bus(if_a.master)
  );
  vqe_sweep_scheduler #(.N_ANG0(2), .N_ANG1(3), .SETTLE_CYC(3), .ENERGY_W(16)) dut_b (
    .i_clock(clk), .i_reset(rst), .bus(if_b.master)
  );

  assign if_a.start         = drv_start[0];
  assign if_a.listener_flag = drv_listener[0];
  assign if_b.start         = drv_start[1];
  assign if_b.listener_flag = drv_listener[1];

  assign o_cap[0]  = if_a.cap_we;
  assign o_busy[0] = if_a.busy;
  assign o_src[0]  = if_a.source_flag;
  assign o_slot[0] = 8'(if_a.cap_slot);
  assign o_a0[0]   = 8'(if_a.ang0_idx);
  assign o_a1[0]   = 8'(if_a.ang1_idx);
  assign o_cap[1]  = if_b.cap_we;
  assign o_busy[1] = if_b.busy;
  assign o_src[1]  = if_b.source_flag;
  assign o_slot[1] = 8'(if_b.cap_slot);
  assign o_a0[1]   = 8'(if_b.ang0_idx);
  assign o_a1[1]   = 8'(if_b.ang1_idx);

`ifdef VQE_ARGMIN_EN
  assign if_a.energy   = drv_energy[0];
  assign if_b.energy   = drv_energy[1];
  assign o_min_slot[0] = 8'(if_a.min_slot);
  assign o_min_slot[1] = 8'(if_b.min_slot);
  assign o_min_e[0]    = if_a.min_energy;
  assign o_min_e[1]    = if_b.min_energy;
`else
  assign o_min_slot[0] = 8'd0;
  assign o_min_slot[1] = 8'd0;
  assign o_min_e[0]    = 16'sd0;
  assign o_min_e[1]    = 16'sd0;
`endif

  // Reset, with start and listener randomly asserted: every output must read zero.
  task automatic test_reset(input int d);
    @(negedge clk);
    rst = 1'b1;
    drv_start[d] = 1'($urandom_range(0, 1));
    drv_listener[d] = 1'($urandom_range(0, 1));
    repeat (2) @(negedge clk);
    checks += 6;
    if (o_cap[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset d%0d cap_we got %b want 0", d, o_cap[d]); end
    if (o_busy[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset d%0d busy got %b want 0", d, o_busy[d]); end
    if (o_src[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset d%0d source_flag got %b want 0", d, o_src[d]); end
    if (o_slot[d] !== 8'd0) begin errors++; $display("[TB] FAIL reset d%0d cap_slot got %0d want 0", d, o_slot[d]); end
    if (o_a0[d] !== 8'd0) begin errors++; $display("[TB] FAIL reset d%0d ang0_idx got %0d want 0", d, o_a0[d]); end
    if (o_a1[d] !== 8'd0) begin errors++; $display("[TB] FAIL reset d%0d ang1_idx got %0d want 0", d, o_a1[d]); end
    rst = 1'b0;
    drv_start[d] = 1'b0;
    drv_listener[d] = 1'b0;
    @(negedge clk);
    checks += 2;
    if (o_busy[d] !== 1'b0) begin errors++; $display("[TB] FAIL post_reset d%0d busy got %b want 0", d, o_busy[d]); end
    if (o_cap[d] !== 1'b0) begin errors++; $display("[TB] FAIL post_reset d%0d cap_we got %b want 0", d, o_cap[d]); end
  endtask

  // One full sweep: start, settle/capture per point, DONE, acknowledge, then a few idle cycles.
  // hold_mode keeps listener_flag high throughout, so DONE must last exactly one cycle.
  // ack_start raises start together with the acknowledge.
  // noise toggles start (and listener before DONE) randomly while they must be ignored.
  task automatic test_sweep(input int d, input bit hold_mode, input bit ack_start,
                            input bit noise, input bit rand_energy);
    int n0, n1, s, n, total, hold, ack_c, last_c;
    int p, ph, e_slot, ms, me;
    logic e_cap, e_busy, e_src;
    n0 = n0_tab[d];
    n1 = n1_tab[d];
    s  = s_tab[d];
    n  = n0 * n1;
    total  = n * (s + 1);
    hold   = hold_mode ? 0 : int'($urandom_range(0, 3));
    ack_c  = total + 1 + hold;
    last_c = ack_c + 3;
    for (int i = 0; i < n; i++) begin
      if (rand_energy) energy_tab[d][i] = 16'($urandom);
      else if (i == 0) energy_tab[d][i] = 16'sd5;
      else if (i == 1) energy_tab[d][i] = 16'sd3;
      else if (i == 2) energy_tab[d][i] = -16'sd2;
      else if (i == 3) energy_tab[d][i] = 16'sd7;
      else if (i == 4) energy_tab[d][i] = -16'sd2;
      else energy_tab[d][i] = 16'(10 + i);
    end
    ms = 0;
    me = int'(energy_tab[d][0]);
    for (int i = 1; i < n; i++) begin
      if (int'(energy_tab[d][i]) < me) begin
        ms = i;
        me = int'(energy_tab[d][i]);
      end
    end
    @(negedge clk);
    drv_start[d] = 1'b1;
    drv_listener[d] = hold_mode;
    drv_energy[d] = energy_tab[d][0];
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (c <= total) begin
        p  = (c - 1) / (s + 1);
        ph = (c - 1) % (s + 1);
        e_cap  = (ph == s);
        e_busy = 1'b1;
        e_src  = 1'b0;
        e_slot = p;
      end else begin
        p      = n - 1;
        e_cap  = 1'b0;
        e_busy = 1'b0;
        e_src  = (c <= ack_c);
        e_slot = n - 1;
      end
      checks += 6;
      if (o_cap[d] !== e_cap) begin errors++; $display("[TB] FAIL sweep d%0d c%0d cap_we got %b want %b", d, c, o_cap[d], e_cap); end
      if (o_busy[d] !== e_busy) begin errors++; $display("[TB] FAIL sweep d%0d c%0d busy got %b want %b", d, c, o_busy[d], e_busy); end
      if (o_src[d] !== e_src) begin errors++; $display("[TB] FAIL sweep d%0d c%0d source_flag got %b want %b", d, c, o_src[d], e_src); end
      if (o_slot[d] !== 8'(e_slot)) begin errors++; $display("[TB] FAIL sweep d%0d c%0d cap_slot got %0d want %0d", d, c, o_slot[d], e_slot); end
      if (o_a0[d] !== 8'(e_slot / n1)) begin errors++; $display("[TB] FAIL sweep d%0d c%0d ang0_idx got %0d want %0d", d, c, o_a0[d], e_slot / n1); end
      if (o_a1[d] !== 8'(e_slot % n1)) begin errors++; $display("[TB] FAIL sweep d%0d c%0d ang1_idx got %0d want %0d", d, c, o_a1[d], e_slot % n1); end
`ifdef VQE_ARGMIN_EN
      if (e_src) begin
        checks += 2;
        if (o_min_slot[d] !== 8'(ms)) begin errors++; $display("[TB] FAIL argmin d%0d c%0d min_slot got %0d want %0d", d, c, o_min_slot[d], ms); end
        if (o_min_e[d] !== 16'(me)) begin errors++; $display("[TB] FAIL argmin d%0d c%0d min_energy got %0d want %0d", d, c, o_min_e[d], me); end
      end
`endif
      if (c < ack_c) begin
        drv_start[d] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (!hold_mode) drv_listener[d] = (noise && c <= total) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (c == ack_c) begin
        drv_listener[d] = 1'b1;
        drv_start[d] = ack_start ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      end else begin
        drv_start[d] = 1'b0;
        drv_listener[d] = hold_mode;
      end
      drv_energy[d] = (c <= total) ? energy_tab[d][(c) / (s + 1) < n ? p : p] : 16'($urandom);
    end
    drv_start[d] = 1'b0;
    drv_listener[d] = 1'b0;
  endtask

  // Reset in the capture cycle of point stop_p: all outputs clear on the next cycle and no restart follows.
  task automatic test_reset_mid(input int d, input int stop_p);
    int s, c_cap;
    s = s_tab[d];
    c_cap = (stop_p + 1) * (s + 1);
    @(negedge clk);
    drv_start[d] = 1'b1;
    for (int c = 1; c <= c_cap; c++) begin
      @(negedge clk);
      drv_start[d] = 1'b0;
    end
    checks += 2;
    if (o_cap[d] !== 1'b1) begin errors++; $display("[TB] FAIL mid_capture d%0d cap_we got %b want 1", d, o_cap[d]); end
    if (o_slot[d] !== 8'(stop_p)) begin errors++; $display("[TB] FAIL mid_capture d%0d cap_slot got %0d want %0d", d, o_slot[d], stop_p); end
    rst = 1'b1;
    drv_start[d] = 1'b1;
    @(negedge clk);
    checks += 6;
    if (o_cap[d] !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset d%0d cap_we got %b want 0", d, o_cap[d]); end
    if (o_busy[d] !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset d%0d busy got %b want 0", d, o_busy[d]); end
    if (o_src[d] !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset d%0d source_flag got %b want 0", d, o_src[d]); end
    if (o_slot[d] !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset d%0d cap_slot got %0d want 0", d, o_slot[d]); end
    if (o_a0[d] !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset d%0d ang0_idx got %0d want 0", d, o_a0[d]); end
    if (o_a1[d] !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset d%0d ang1_idx got %0d want 0", d, o_a1[d]); end
    rst = 1'b0;
    drv_start[d] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks += 2;
      if (o_cap[d] !== 1'b0) begin errors++; $display("[TB] FAIL after_reset d%0d k%0d cap_we got %b want 0", d, k, o_cap[d]); end
      if (o_busy[d] !== 1'b0) begin errors++; $display("[TB] FAIL after_reset d%0d k%0d busy got %b want 0", d, k, o_busy[d]); end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      drv_start[d] = 1'b0;
      drv_listener[d] = 1'b0;
      drv_energy[d] = 16'sd0;
    end
    $display("[TB] vqe_sweep_scheduler bench starting");
    test_reset(0);
    test_reset(1);
    test_sweep(0, 1'b0, 1'b0, 1'b0, 1'b0);
    test_sweep(1, 1'b0, 1'b0, 1'b0, 1'b0);
    test_sweep(0, 1'b0, 1'b1, 1'b1, 1'b1);
    test_sweep(1, 1'b0, 1'b1, 1'b1, 1'b1);
    test_sweep(0, 1'b1, 1'b1, 1'b0, 1'b1);
    test_sweep(1, 1'b1, 1'b0, 1'b1, 1'b1);
    test_reset_mid(0, 7);
    test_sweep(0, 1'b0, 1'b0, 1'b1, 1'b1);
    test_reset_mid(1, int'($urandom_range(0, 4)));
    test_sweep(1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      test_sweep(i % 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vqe_sweep_scheduler.md
Name: vqe_sweep_scheduler

Overview:
Sequencer that steps the variational circuit through a 2-D grid of angle-index pairs and strobes capture of each resulting psi_f slot into the result buffer. Drives the angle-index selects that feed the V-matrix lookup for v_matrix0 and v_matrix1. Waits a programmable settle time per point, then raises source_flag and holds it until output_2qb acknowledges on listener_flag. Replaces hard-coded per-angle case sequencing with a parameterised FSM clocked on shared_clock.

Parameters:
N_ANG0, 4, number of angle steps for qubit-0 parameter (outer loop), >=1
N_ANG1, 4, number of angle steps for qubit-1 parameter (inner loop), >=1
SETTLE_CYC, 1, cycles per point between index change and capture, >=1
ENERGY_W, 16, width of signed energy input (used only with optional feature)

Ports:
i_clock  in  1  shared_clock domain clock
i_reset  in  1  synchronous active-high reset
start  in  1  begin sweep; sampled only in IDLE
listener_flag  in  1  consumer acknowledge of completed sweep
ang0_idx  out  max(1,$clog2(N_ANG0))  angle index for v_matrix0 lookup
ang1_idx  out  max(1,$clog2(N_ANG1))  angle index for v_matrix1 lookup
cap_we  out  1  one-cycle strobe: write psi_f into buffer slot cap_slot
cap_slot  out  max(1,$clog2(N_ANG0*N_ANG1))  destination slot, = ang0_idx*N_ANG1 + ang1_idx
busy  out  1  high in SETTLE or CAPTURE
source_flag  out  1  sweep complete, results valid

Behaviour:
- Reset: state IDLE; ang0_idx=0, ang1_idx=0, cap_slot=0, cap_we=0, busy=0, source_flag=0, settle counter=0. Reset takes priority over everything, including mid-sweep; no cap_we is issued on the reset edge or after it.
- All outputs registered.
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE: start=1 -> SETTLE next cycle with indices/slot=0, counter loaded with SETTLE_CYC-1, busy=1.
- SETTLE: counter decrements each cycle; at 0 -> CAPTURE. Exactly SETTLE_CYC cycles in SETTLE per point.
- CAPTURE: one cycle, cap_we=1, cap_slot = current slot. If last point (ang0_idx=N_ANG0-1 and ang1_idx=N_ANG1-1) -> DONE; else advance: ang1_idx+1, wrapping to 0 with ang0_idx+1; slot+1; counter reloaded -> SETTLE.
- Per-point cost SETTLE_CYC+1 cycles; sweep = N_ANG0*N_ANG1*(SETTLE_CYC+1) cycles. First cap_we is SETTLE_CYC+1 cycles after start is sampled.
- DONE: busy=0, source_flag=1, indices hold last point. listener_flag=1 -> IDLE next cycle, source_flag=0. Indices then hold until the next start reloads zeros.
- start outside IDLE is ignored, including start and listener_flag together in DONE: ack wins, return to IDLE, no restart.
- listener_flag outside DONE is ignored.
- N_ANG0=N_ANG1=1: single point, then DONE.

Optional Feature:
VQE_ARGMIN_EN
- Defined: adds input energy[ENERGY_W-1:0] (signed, sampled on CAPTURE cycle) and outputs min_slot (cap_slot width) and min_energy[ENERGY_W-1:0].
  - First capture of a sweep loads both unconditionally; later captures update only if energy < min_energy, strict, so ties keep the earlier slot.
  - Reset value 0; values are valid while source_flag=1.
- Undefined: these ports and this logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, start pulse at cycle 0 -> cap_we high at cycles 2,4,...,32 with cap_slot 0..15; (ang0,ang1) pairs run (0,0),(0,1),(0,2),(0,3),(1,0)...; source_flag=1 from cycle 33.
- SETTLE_CYC=3, N_ANG0=2, N_ANG1=3 -> 6 strobes spaced 4 cycles apart, slot 5 maps to (1,2); busy low in DONE.
- Pulse start during SETTLE and during DONE -> no restart or extra cap_we; listener_flag asserted together with start in DONE -> returns to IDLE, source_flag=0 next cycle, stays idle.
- Assert i_reset after slot 7 capture -> all outputs 0 next cycle; new start sweeps from slot 0 again.
- listener_flag held high from cycle 0 -> no effect until DONE; at DONE the FSM exits after exactly one cycle of source_flag.
- VQE_ARGMIN_EN, energy per slot = {5,3,-2,7,-2,...} (others positive) -> min_slot=2, min_energy=-2 at DONE.
